// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply sequencer.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_e;

  localparam int M_DEF  = 2;
  localparam int K_DEF  = 2;
  localparam int P_DEF  = 2;
  localparam int DW_DEF = 8;

  // Full-precision accumulator width for k products of two dw-bit operands.
  function automatic int accw(input int dw, input int k);
    return 2 * dw + $clog2(k + 1);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Unsigned multiplier feeding an accumulator that reloads on the first term.
module matmul_mac #(
  parameter int DW   = 8,
  parameter int ACCW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          first,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc_lo
);

  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] acc_d, acc_q;

  always_comb begin
    prod  = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    acc_d = acc_q;
    if (en) acc_d = first ? ACCW'(prod) : acc_q + ACCW'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // Only the low element-width bits leave the block; C stores are DW wide.
  assign acc_lo = acc_q[DW-1:0];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequences C = A x B one product per cycle, writing C in row-major order.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int M    = M_DEF,
  parameter int K    = K_DEF,
  parameter int P    = P_DEF,
  parameter int DW   = DW_DEF,
  parameter int ACCW = accw(DW, K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] a_row,
  output logic [DW-1:0] a_col,
  input  logic [DW-1:0] a_data,
  output logic [DW-1:0] b_row,
  output logic [DW-1:0] b_col,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] c_row,
  output logic [DW-1:0] c_col,
  output logic [DW-1:0] c_wdata,
  output logic          c_we
);

  localparam logic [DW-1:0] M_LAST = DW'(M - 1);
  localparam logic [DW-1:0] K_LAST = DW'(K - 1);
  localparam logic [DW-1:0] P_LAST = DW'(P - 1);
  localparam logic [DW-1:0] ONE    = DW'(1);

  state_e        state_d, state_q;
  logic [DW-1:0] i_d, i_q, j_d, j_q, k_d, k_q;
  logic          busy_d, busy_q, done_d, done_q, c_we_d, c_we_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = MAC;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
      end
      MAC: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = WRITE;
        end else begin
          k_d = k_q + ONE;
        end
      end
      WRITE: begin
        state_d = MAC;
        if (j_q == P_LAST) begin
          j_d = '0;
          // i also wraps so every select reads 0 once the run finishes
          if (i_q == M_LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + ONE;
          end
        end else begin
          j_d = j_q + ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    c_we_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_we_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_we_q  <= c_we_d;
    end
  end

  matmul_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == MAC),
    .first  (k_q == '0),
    .a      (a_data),
    .b      (b_data),
    .acc_lo (c_wdata)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign c_we  = c_we_q;
  assign a_row = i_q;
  assign a_col = k_q;
  assign b_row = k_q;
  assign b_col = j_q;
  assign c_row = i_q;
  assign c_col = j_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: 2x2x2 instance plus a 1x3x1 instance.
module tb_matmul_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, busy, done, c_we;
  logic [7:0] a_row, a_col, a_data, b_row, b_col, b_data, c_row, c_col, c_wdata;
  logic       start1 = 1'b0, busy1, done1, c_we1;
  logic [7:0] a_row1, a_col1, a_data1, b_row1, b_col1, b_data1, c_row1, c_col1, c_wdata1;

  logic [7:0] am[4], bm[4], a1m[3], b1m[3];

  matmul_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .a_row(a_row), .a_col(a_col), .a_data(a_data),
    .b_row(b_row), .b_col(b_col), .b_data(b_data),
    .c_row(c_row), .c_col(c_col), .c_wdata(c_wdata), .c_we(c_we)
  );

  matmul_seq_ctrl #(.M(1), .K(3), .P(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .a_row(a_row1), .a_col(a_col1), .a_data(a_data1),
    .b_row(b_row1), .b_col(b_col1), .b_data(b_data1),
    .c_row(c_row1), .c_col(c_col1), .c_wdata(c_wdata1), .c_we(c_we1)
  );

  // Combinational matrix stores
  always_comb begin
    a_data = '0;
    b_data = '0;
    if (a_row < 8'd2 && a_col < 8'd2) a_data = am[int'(a_row) * 2 + int'(a_col)];
    if (b_row < 8'd2 && b_col < 8'd2) b_data = bm[int'(b_row) * 2 + int'(b_col)];
  end

  always_comb begin
    a_data1 = '0;
    b_data1 = '0;
    if (a_row1 == 8'd0 && a_col1 < 8'd3) a_data1 = a1m[int'(a_col1)];
    if (b_col1 == 8'd0 && b_row1 < 8'd3) b_data1 = b1m[int'(b_row1)];
  end

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] c;
    logic [7:0] d;
  } wr_t;

  wr_t q[$], q1[$];
  wr_t e, e1;
  int  checks = 0, errors = 0;
  int  wr_cnt = 0, wr_cnt1 = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (c_we === 1'b1) begin
      wr_cnt++;
      chk("write_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("c_row", c_row, e.r);
        chk("c_col", c_col, e.c);
        chk("c_wdata", c_wdata, e.d);
      end
    end
    if (c_we1 === 1'b1) begin
      wr_cnt1++;
      chk("write_expected1", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("c_row1", c_row1, e1.r);
        chk("c_col1", c_col1, e1.c);
        chk("c_wdata1", c_wdata1, e1.d);
      end
    end
  end

  // Element e of av/bv sits at bits [8*e +: 8], row-major.
  task automatic load(input logic [31:0] av, input logic [31:0] bv);
    int s;
    for (int n = 0; n < 4; n++) begin
      am[n] = av[8*n +: 8];
      bm[n] = bv[8*n +: 8];
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += int'(am[i*2+k]) * int'(bm[k*2+j]);
        q.push_back(wr_t'{8'(i), 8'(j), s[7:0]});
      end
  endtask

  // Entered and left at 1ns after a rising edge with the DUT in IDLE.
  task automatic run(input int exp_lat, input bit repulse);
    int cyc, w0, d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    chk("busy_after_start", busy, 1);
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = repulse && (cyc == 3 || cyc == 7);
    end
    start = repulse;
    chk("done_latency", cyc, exp_lat);
    chk("busy_in_done", busy, 1);
    chk("write_count", wr_cnt - w0, 4);
    chk("queue_drained", q.size(), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse_width", done, 0);
    chk("busy_idle", busy, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("idle_ab_sel", {a_row, a_col, b_row, b_col}, 0);
    chk("idle_c_sel", {c_row, c_col, 7'd0, c_we}, 0);
  endtask

  initial begin
    int cyc;
    #2;
    chk("rst_flags", {busy, done, c_we}, 0);
    chk("rst_ab_sel", {a_row, a_col, b_row, b_col}, 0);
    chk("rst_c_sel", {c_row, c_col}, 0);
    chk("rst_flags1", {busy1, done1, c_we1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity times [[1,2],[3,4]]
    load({8'd1, 8'd0, 8'd0, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1});
    run(12, 1'b0);
    // [[1,2],[3,4]] x [[5,6],[7,8]], started the cycle after done
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    run(12, 1'b0);
    // Saturated operands: low byte of 130050
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(12, 1'b0);
    // Re-pulsed start mid-run and during DONE must be ignored
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    run(12, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("no_restart_busy", busy, 0);
    chk("no_restart_writes", wr_cnt, 16);

    // Async reset during the first WRITE
    load({8'd1, 8'd0, 8'd0, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("c_we_before_rst", c_we, 1);
    #1 rst = 1'b1;
    #1;
    chk("c_we_in_rst", c_we, 0);
    chk("busy_in_rst", busy, 0);
    chk("sel_in_rst", {a_row, a_col, c_row, c_col}, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    load({8'd1, 8'd0, 8'd0, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1});
    run(12, 1'b0);

    // 1x3 by 3x1 instance
    a1m[0] = 8'd1; a1m[1] = 8'd2; a1m[2] = 8'd3;
    b1m[0] = 8'd4; b1m[1] = 8'd5; b1m[2] = 8'd6;
    q1.push_back(wr_t'{8'd0, 8'd0, 8'd32});
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0;
    chk("busy1_after_start", busy1, 1);
    while (done1 !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done1_latency", cyc, 4);
    chk("write_count1", wr_cnt1, 1);
    chk("queue1_drained", q1.size(), 0);
    @(posedge clk); #1;
    chk("busy1_idle", {busy1, done1}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
